// File: rtl/data_mem_ls.sv
// data_mem_ls: byte-strobed load/store data memory with an RD_LAT-stage load pipe.
// Optional: define DM_MISALIGN_CHECK_EN to reject misaligned accesses instead of aligning them.
module data_mem_ls #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              dm_clk,
    input  logic              dm_rst,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [AWIDTH-1:0] dm_addr,
    input  logic [DWIDTH-1:0] dm_data_in,
    output logic              dm_ready,
    output logic              dm_rvalid,
    output logic [DWIDTH-1:0] dm_data_out,
    output logic              dm_err
);

    localparam int NB = DWIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] perr_q, perr_d;
    logic [DWIDTH-1:0] pdata_q [RD_LAT];
    logic [DWIDTH-1:0] pdata_d [RD_LAT];
    logic              st_err_q, st_err_d;

    logic              busy;
    logic              acc;
    logic              ld_acc;
    logic              st_acc;
    logic              illegal;
    logic [1:0]        sz;
    logic [NB-1:0]     size_mask;
    logic [NB-1:0]     strobe;
    logic [LB-1:0]     lane;
    logic [LB-1:0]     amask;
    logic [LB-1:0]     lane_al;
    logic [LB+2:0]     sh;
    logic [IW-1:0]     idx;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rword;
    logic [DWIDTH-1:0] rshift;
    logic [DWIDTH-1:0] ldata;
    int                nbits;

    if (AWIDTH > LB + IW) begin : g_hi
        logic addr_unused;
        assign addr_unused = ^dm_addr[AWIDTH-1:LB+IW];
    end

    assign sz   = dm_funct3[1:0];
    assign lane = dm_addr[LB-1:0];
    assign idx  = dm_addr[LB +: IW];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            busy = busy | vld_q[i];
        end
    end

    assign dm_ready = !dm_rst && !busy;
    assign acc      = dm_req && dm_ready;
    assign ld_acc   = acc && !dm_we;
    assign st_acc   = acc && dm_we;

    // Lane alignment: clear lane bits below the access size.
    always_comb begin
        for (int i = 0; i < LB; i++) begin
            amask[i] = (i >= int'(sz));
        end
        for (int i = 0; i < NB; i++) begin
            size_mask[i] = (i < (1 << sz));
        end
        lane_al = lane & amask;
        sh      = {lane_al, 3'b000};
        strobe  = size_mask << lane_al;
        wdata   = dm_data_in << sh;
    end

    always_comb begin
        illegal = (dm_funct3 == 3'b111) || (dm_we && dm_funct3[2]);
        if (DWIDTH == 32 && (sz == 2'b11 || dm_funct3 == 3'b110)) begin
            illegal = 1'b1;
        end
`ifdef DM_MISALIGN_CHECK_EN
        if (|(lane & ~amask)) begin
            illegal = 1'b1;
        end
`endif
    end

    always_comb begin
        rword  = mem[idx];
        rshift = rword >> sh;
        nbits  = 8 << sz;
        if (nbits > DWIDTH) begin
            nbits = DWIDTH;
        end
        for (int i = 0; i < DWIDTH; i++) begin
            if (i < nbits) begin
                ldata[i] = rshift[i];
            end else begin
                ldata[i] = ~dm_funct3[2] & rshift[nbits-1];
            end
        end
    end

    always_comb begin
        vld_d  = '0;
        perr_d = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            pdata_d[i] = pdata_q[i];
        end
        vld_d[0]   = ld_acc;
        perr_d[0]  = illegal;
        pdata_d[0] = illegal ? '0 : ldata;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            perr_d[i]  = perr_q[i-1];
            pdata_d[i] = pdata_q[i-1];
        end
        // Output stage keeps the last load result between responses.
        if (!vld_d[RD_LAT-1]) begin
            pdata_d[RD_LAT-1] = pdata_q[RD_LAT-1];
        end
        st_err_d = st_acc && illegal;
    end

    always_ff @(posedge dm_clk) begin
        if (dm_rst) begin
            vld_q    <= '0;
            perr_q   <= '0;
            st_err_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pdata_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            perr_q   <= perr_d;
            st_err_q <= st_err_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pdata_q[i] <= pdata_d[i];
            end
        end
    end

    always_ff @(posedge dm_clk) begin
        if (st_acc && !illegal) begin
            for (int b = 0; b < NB; b++) begin
                if (strobe[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign dm_rvalid   = vld_q[RD_LAT-1];
    assign dm_data_out = pdata_q[RD_LAT-1];
    assign dm_err      = st_err_q | (vld_q[RD_LAT-1] & perr_q[RD_LAT-1]);

endmodule

// File: tb/tb_data_mem_ls.sv
// tb_data_mem_ls: two instances (32-bit RD_LAT=1, 64-bit RD_LAT=3, DEPTH=16)
// checked every cycle against a byte-array transaction model.
module tb_data_mem_ls;

    logic        clk;
    logic        rst;
    logic        req_i [2];
    logic        we_i  [2];
    logic [2:0]  f_i   [2];
    logic [31:0] a_i   [2];
    logic [63:0] d_i   [2];

    logic        rdy_a, rv_a, er_a;
    logic [31:0] do_a;
    logic        rdy_b, rv_b, er_b;
    logic [63:0] do_b;

    logic        rdy_o [2];
    logic        rv_o  [2];
    logic        er_o  [2];
    logic [63:0] do_o  [2];

    int errs;
    int checks;
    bit chk_on;

    logic [7:0]  mm   [2][128];
    bit          pend [2];
    int          due  [2];
    logic [63:0] pdat [2];
    bit          perr [2];
    bit          e_rv [2];
    bit          e_er [2];
    logic [63:0] e_do [2];
    int          ecnt;

    logic [63:0] fill0 [2];

    data_mem_ls #(
        .DWIDTH(32), .AWIDTH(32), .DEPTH(16), .RD_LAT(1)
    ) u_a (
        .dm_clk(clk),
        .dm_rst(rst),
        .dm_req(req_i[0]),
        .dm_we(we_i[0]),
        .dm_funct3(f_i[0]),
        .dm_addr(a_i[0]),
        .dm_data_in(d_i[0][31:0]),
        .dm_ready(rdy_a),
        .dm_rvalid(rv_a),
        .dm_data_out(do_a),
        .dm_err(er_a)
    );

    data_mem_ls #(
        .DWIDTH(64), .AWIDTH(32), .DEPTH(16), .RD_LAT(3)
    ) u_b (
        .dm_clk(clk),
        .dm_rst(rst),
        .dm_req(req_i[1]),
        .dm_we(we_i[1]),
        .dm_funct3(f_i[1]),
        .dm_addr(a_i[1]),
        .dm_data_in(d_i[1]),
        .dm_ready(rdy_b),
        .dm_rvalid(rv_b),
        .dm_data_out(do_b),
        .dm_err(er_b)
    );

    assign rdy_o[0] = rdy_a;
    assign rdy_o[1] = rdy_b;
    assign rv_o[0]  = rv_a;
    assign rv_o[1]  = rv_b;
    assign er_o[0]  = er_a;
    assign er_o[1]  = er_b;
    assign do_o[0]  = {32'b0, do_a};
    assign do_o[1]  = do_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbk(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int latk(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit bad(input int k, input bit we,
                               input logic [2:0] f, input logic [31:0] a);
        int n;
        n = 1 << f[1:0];
        if (f == 3'b111 || (we && f[2])) return 1'b1;
        if (nbk(k) == 4 && (n == 8 || f == 3'b110)) return 1'b1;
`ifdef DM_MISALIGN_CHECK_EN
        if (a % n != 0) return 1'b1;
`else
        if (a === 32'hxxxx_xxxx) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // First byte touched: wrapped word base plus size-aligned lane.
    function automatic int first_byte(input int k, input logic [2:0] f,
                                      input logic [31:0] a);
        int nb, n, w, ln;
        nb = nbk(k);
        n  = 1 << f[1:0];
        w  = int'((a / nb) % 16);
        ln = (int'(a % nb) / n) * n;
        return w * nb + ln;
    endfunction

    function automatic logic [63:0] ld_val(input int k, input logic [2:0] f,
                                           input logic [31:0] a);
        logic [63:0] v;
        int n, b;
        n = 1 << f[1:0];
        b = first_byte(k, f, a);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[k][b+i];
        if (!f[2] && n < nbk(k) && v[8*n-1])
            v = v | ~((64'd1 << (8*n)) - 64'd1);
        if (nbk(k) == 4) v[63:32] = '0;
        return v;
    endfunction

    always @(posedge clk) begin
        bit il;
        int b;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = 1'b0;
                e_rv[k] = 1'b0;
                e_er[k] = 1'b0;
                e_do[k] = '0;
            end else begin
                e_rv[k] = 1'b0;
                e_er[k] = 1'b0;
                if (req_i[k] && !pend[k]) begin
                    il = bad(k, we_i[k], f_i[k], a_i[k]);
                    if (we_i[k]) begin
                        if (il) begin
                            e_er[k] = 1'b1;
                        end else begin
                            b = first_byte(k, f_i[k], a_i[k]);
                            for (int i = 0; i < (1 << f_i[k][1:0]); i++)
                                mm[k][b+i] = d_i[k][8*i +: 8];
                        end
                    end else begin
                        pend[k] = 1'b1;
                        due[k]  = ecnt + latk(k) - 1;
                        pdat[k] = il ? 64'd0 : ld_val(k, f_i[k], a_i[k]);
                        perr[k] = il;
                    end
                end
                if (pend[k] && due[k] == ecnt) begin
                    e_rv[k] = 1'b1;
                    e_er[k] = perr[k];
                    e_do[k] = pdat[k];
                    pend[k] = 1'b0;
                end
            end
        end
        ecnt++;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ready%0d", k), 64'(rdy_o[k]),
                      64'(!rst && !pend[k]));
                check($sformatf("rvalid%0d", k), 64'(rv_o[k]), 64'(e_rv[k]));
                check($sformatf("err%0d", k), 64'(er_o[k]), 64'(e_er[k]));
                check($sformatf("dout%0d", k), do_o[k], e_do[k]);
            end
        end
    end

    task automatic issue(input int k, input bit we, input logic [2:0] f,
                         input logic [31:0] a, input logic [63:0] d);
        bit took;
        req_i[k] = 1'b1;
        we_i[k]  = we;
        f_i[k]   = f;
        a_i[k]   = a;
        d_i[k]   = d;
        took = 1'b0;
        for (int n = 0; n < 20 && !took; n++) begin
            took = !rst && !pend[k];
            @(posedge clk);
            #1;
        end
        if (!took) check("accept_timeout", 64'd0, 64'd1);
        req_i[k] = 1'b0;
    endtask

    task automatic load_chk(input int k, input string tag,
                            input logic [2:0] f, input logic [31:0] a,
                            input logic [63:0] exp, input bit exp_err);
        int n;
        issue(k, 1'b0, f, a, 64'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv_o[k] && n < 10);
        check({tag, "_lat"}, 64'(n), 64'(latk(k)));
        check({tag, "_data"}, do_o[k], exp);
        check({tag, "_err"}, 64'(er_o[k]), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int seen;
        errs   = 0;
        checks = 0;
        chk_on = 1'b0;
        ecnt   = 0;
        rst    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_i[k] = 1'b0;
            we_i[k]  = 1'b0;
            f_i[k]   = 3'b010;
            a_i[k]   = '0;
            d_i[k]   = '0;
        end
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int w = 0; w < 16; w++) begin
            d = {32'd0, $urandom};
            if (w == 0) fill0[0] = d;
            issue(0, 1'b1, 3'b010, 32'(w * 4), d);
            d = {$urandom, $urandom};
            if (w == 0) fill0[1] = d;
            issue(1, 1'b1, 3'b011, 32'(w * 8), d);
        end

        // Reset held 2 cycles with a store request pending on both.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_i[k] = 1'b1;
            we_i[k]  = 1'b1;
            f_i[k]   = (k == 0) ? 3'b010 : 3'b011;
            a_i[k]   = '0;
            d_i[k]   = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        @(negedge clk);
        check("rst_ready", 64'(rdy_a), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_i[0] = 1'b0;
        req_i[1] = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(rdy_a), 64'd1);
        load_chk(0, "rst_nowrite_a", 3'b010, 32'h0, fill0[0], 1'b0);
        load_chk(1, "rst_nowrite_b", 3'b011, 32'h0, fill0[1], 1'b0);

        issue(0, 1'b1, 3'b010, 32'h10, 64'h8081_8283);
        load_chk(0, "lb10", 3'b000, 32'h10, 64'hFFFF_FF83, 1'b0);
        load_chk(0, "lbu10", 3'b100, 32'h10, 64'h0000_0083, 1'b0);
        load_chk(0, "lb11", 3'b000, 32'h11, 64'hFFFF_FF82, 1'b0);
        load_chk(0, "lh12", 3'b001, 32'h12, 64'hFFFF_8081, 1'b0);
        load_chk(0, "lhu12", 3'b101, 32'h12, 64'h0000_8081, 1'b0);
        load_chk(0, "lw10", 3'b010, 32'h10, 64'h8081_8283, 1'b0);

        issue(0, 1'b1, 3'b010, 32'h20, 64'h1122_3344);
        issue(0, 1'b1, 3'b000, 32'h23, 64'h55);
        load_chk(0, "sb_merge", 3'b010, 32'h20, 64'h5522_3344, 1'b0);

        issue(0, 1'b1, 3'b010, 32'h40, 64'hA5);
        load_chk(0, "wrap_a", 3'b010, 32'h0, 64'hA5, 1'b0);

        issue(0, 1'b1, 3'b010, 32'h24, 64'hCAFE_F00D);
        issue(0, 1'b1, 3'b111, 32'h24, 64'h0);
        @(negedge clk);
        check("st111_err", 64'(er_a), 64'd1);
        load_chk(0, "st111_nowr", 3'b010, 32'h24, 64'hCAFE_F00D, 1'b0);
        issue(0, 1'b1, 3'b100, 32'h24, 64'h77);
        @(negedge clk);
        check("st1xx_err", 64'(er_a), 64'd1);
        load_chk(0, "ld_d32", 3'b011, 32'h10, 64'h0, 1'b1);
`ifdef DM_MISALIGN_CHECK_EN
        load_chk(0, "lw_mis", 3'b010, 32'h2, 64'h0, 1'b1);
`else
        load_chk(0, "lw_mis", 3'b010, 32'h2, 64'hA5, 1'b0);
`endif

        issue(1, 1'b1, 3'b011, 32'h8, 64'h8081_8283_8485_8687);
        load_chk(1, "lw8_b", 3'b010, 32'h8, 64'hFFFF_FFFF_8485_8687, 1'b0);
        load_chk(1, "lwu_c", 3'b110, 32'hC, 64'h0000_0000_8081_8283, 1'b0);
        load_chk(1, "ld8", 3'b011, 32'h8, 64'h8081_8283_8485_8687, 1'b0);
        load_chk(1, "lh_e", 3'b001, 32'hE, 64'hFFFF_FFFF_FFFF_8081, 1'b0);
        load_chk(1, "lb_f", 3'b000, 32'hF, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        issue(1, 1'b1, 3'b011, 32'h80, 64'hA5);
        load_chk(1, "wrap_b", 3'b011, 32'h0, 64'hA5, 1'b0);

        // Reset one edge after a load is accepted: response must vanish.
        issue(1, 1'b0, 3'b011, 32'h8, 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv_b) seen++;
        end
        check("rst_drop_rv", 64'(seen), 64'd0);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 200; n++) begin
                issue(k, 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 32 * nbk(k) - 1)),
                      {$urandom, $urandom});
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
